// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32-bit multiply/divide unit that owns the HI/LO register pair.
// It runs MULT, MULTU, DIV and DIVU behind a start/busy/done handshake.
// A multiply uses shift-add and a divide uses restoring division. Each takes
// 32 iterations on unsigned magnitudes, then one fix-up cycle that applies
// the sign correction and writes HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   in0[31:0]    multiplicand / dividend (sampled with start)
//   in1[31:0]    multiplier / divisor (sampled with start)
//   busy         operation in progress (registered, state != IDLE)
//   done         one-cycle pulse, hi/lo hold the new result
//   div_by_zero  valid with done, set for a divide with a zero divisor
//   hi[31:0]     product[63:32] or remainder
//   lo[31:0]     product[31:0] or quotient
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  cnt_r;
  // Multiply: 64-bit product accumulator.
  // Divide: remainder in [63:32] and quotient in [31:0].
  logic [63:0] acc_r;
  logic [31:0] opb_r;       // multiplicand magnitude or divisor magnitude
  logic [31:0] dividend_r;  // original in0, returned in HI on divide-by-zero
  logic        is_div_r;
  logic        neg_lo_r;    // product / quotient sign
  logic        neg_rem_r;   // remainder sign
  logic        dbz_r;

  logic        signed_op_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] rem_sh_s;
  logic        rem_ge_s;
  logic [31:0] rem_diff_s;
  logic [63:0] div_next_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] hi_next_s;
  logic [31:0] lo_next_s;

  // Magnitude of a value: the two's-complement absolute value when it is signed.
  // The unsigned form passes the value through unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    mag32 = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Optional 32-bit two's-complement negate.
  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    cneg32 = neg ? (~v + 32'd1) : v;
  endfunction

  // Optional 64-bit two's-complement negate.
  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    cneg64 = neg ? (~v + 64'd1) : v;
  endfunction

  assign signed_op_s = ~op[0];

  // Next-state logic for the IDLE -> RUN -> FIX -> IDLE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd31) begin
          state_next_s = FIX;
        end else begin
          state_next_s = RUN;
        end
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // One shift-add step. The carry out of the upper-half add is shifted back in.
  always_comb begin
    mul_sum_s  = 33'd0;
    mul_next_s = 64'd0;
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    mul_next_s = {mul_sum_s, acc_r[31:1]};
  end

  // One restoring-division step.
  // The remainder is always below the divisor, so the shifted remainder fits
  // in 33 bits. A successful trial difference fits back in 32 bits.
  always_comb begin
    rem_sh_s   = {acc_r[63:32], acc_r[31]};
    rem_ge_s   = (rem_sh_s >= {1'b0, opb_r});
    rem_diff_s = rem_sh_s[31:0] - opb_r;
    div_next_s = 64'd0;
    if (rem_ge_s) begin
      div_next_s = {rem_diff_s, acc_r[30:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
    end
  end

  // Sign fix-up and HI/LO selection used in the FIX cycle.
  always_comb begin
    prod_s    = cneg64(acc_r, neg_lo_r);
    quot_s    = cneg32(acc_r[31:0], neg_lo_r);
    rem_s     = cneg32(acc_r[63:32], neg_rem_r);
    hi_next_s = 32'd0;
    lo_next_s = 32'd0;
    if (dbz_r) begin
      hi_next_s = dividend_r;
      lo_next_s = 32'hFFFF_FFFF;
    end else if (is_div_r) begin
      hi_next_s = rem_s;
      lo_next_s = quot_s;
    end else begin
      hi_next_s = prod_s[63:32];
      lo_next_s = prod_s[31:0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      acc_r       <= 64'd0;
      opb_r       <= 32'd0;
      dividend_r  <= 32'd0;
      is_div_r    <= 1'b0;
      neg_lo_r    <= 1'b0;
      neg_rem_r   <= 1'b0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      busy        <= (state_next_s != IDLE);
      done        <= (state_r == FIX);
      div_by_zero <= (state_r == FIX) && dbz_r;
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r      <= 5'd0;
            is_div_r   <= op[1];
            dividend_r <= in0;
            neg_lo_r   <= signed_op_s && (in0[31] ^ in1[31]);
            neg_rem_r  <= signed_op_s && in0[31];
            dbz_r      <= op[1] && (in1 == 32'd0);
            if (op[1]) begin
              // Divide: the quotient half starts as the dividend and is shifted out.
              acc_r <= {32'd0, mag32(in0, signed_op_s)};
              opb_r <= mag32(in1, signed_op_s);
            end else begin
              // Multiply: the multiplier sits in the low half and is consumed LSB first.
              acc_r <= {32'd0, mag32(in1, signed_op_s)};
              opb_r <= mag32(in0, signed_op_s);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + 5'd1;
          if (is_div_r) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
        end
        FIX: begin
          hi <= hi_next_s;
          lo <= lo_next_s;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

endmodule
